uart_txsm: RTL and testbench
============================

Name: uart_txsm

Overview:
- Transmit state machine and shift register for the Parallel Interface UART. It is the transmit-side counterpart of the UART receive SM.
- Takes characters from the Transmit Holding Register/FIFO and serializes them on TxD: start bit, 7 or 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Format encoding and the 16x bit-rate enable are shared with the receiver, so a TX/RX loopback is format-consistent.

Parameters:
- pBitTime, 16, CE_16x ticks per serial bit (prescaler terminal count + 1); fixed at 16 for the UART.

Ports:
- Clk  in  1  system clock; single clock domain
- Rst  in  1  synchronous, active-high reset
- CE_16x  in  1  clock enable at 16x baud rate
- Len  in  1  word length: 0 = 8 bits; 1 = 7 bits (7-bit forces a parity bit)
- NumStop  in  1  0 = 1 stop bit; 1 = 2 stop bits
- ParEn  in  1  parity enable (8-bit formats only)
- Par  in  2  parity: 0 = odd; 1 = even; 2 = space (0); 3 = mark (1)
- TF_EF  in  1  transmit FIFO/THR empty flag; 0 = character available
- THR  in  8  transmit holding register data, valid while TF_EF = 0
- RE_THR  out  1  one-Clk read strobe to the THR/FIFO; pulses on load
- TxD  out  1  serial transmit data, registered; idle = mark (1)
- TxIdle  out  1  state = pIdle
- TxStart  out  1  state = pStart
- TxShift  out  1  state is any pShift0..pShift7
- TxParity  out  1  state = pParity
- TxStop  out  1  state = pStop1 or pStop2
- TxBusy  out  1  ~TxIdle (character in progress)

Behaviour:
- Reset (synchronous, Rst = 1 at posedge Clk):
  - State = pIdle, TxD = 1, RE_THR = 0, TSR = 0, BCnt = 15.
  - Rst asserted mid-frame aborts the frame: TxD = 1 on the next Clk, no further RE_THR.
- Prescaler:
  - 4-bit BCnt is held at 15 in pIdle; otherwise it decrements on CE_16x.
  - TC = CE_16x & (BCnt == 0). Every serial bit is exactly 16 CE_16x ticks.
- Load (in pIdle, on CE_16x with TF_EF = 0):
  - THR → TSR[7:0].
  - Len, NumStop, ParEn and Par are latched into internal format registers; later changes have no effect on the frame in progress.
  - RE_THR = 1 for exactly one Clk, coincident with the Clk edge that enters pStart.
  - TxD is driven low from that edge.
- Parity bit, computed at load from the latched format:
  - odd: ~^data
  - even: ^data
  - space: 0
  - mark: 1
  - data = TSR[6:0] when Len = 1, TSR[7:0] when Len = 0.
- Transitions (advance on TC only):
  - pStart → pShift0 → … → pShift6.
  - pShift6 → pParity if Len = 1, else pShift7.
  - pShift7 → pParity if ParEn = 1, else pStop2 if NumStop = 1, else pStop1.
  - pParity → pStop2 if NumStop = 1, else pStop1.
  - pStop2 → pStop1.
  - pStop1 → pStart with a new load (RE_THR pulse) if TF_EF = 0, else pIdle.
  - Back-to-back characters therefore have no idle gap beyond the stop bits.
- TxD per state:
  - pStart: 0
  - pShiftN: TSR[N]
  - pParity: parity bit
  - pStop1 / pStop2: 1
  - pIdle: 1
  - TxD is registered, so it changes on the same Clk edge as the state.
- Unused state encodings go to pIdle with TxD = 1.
- Frame lengths in CE_16x ticks:
  - 8N1 = 160
  - 7E1 / 7O1 = 160
  - 8E2 = 192
- TF_EF deasserting mid-frame has no effect until pStop1 ends.
- RE_THR is never asserted while TF_EF = 1.

Optional Feature:
- Macro: UART_TXSM_CTS_EN.
- When defined:
  - Adds input port CTS (1 bit, active-high, asynchronous), synchronized with a 2-FF synchronizer on Clk.
  - A load, both from pIdle and from the pStop1 → pStart chaining, additionally requires synchronized CTS = 1.
  - Deasserting CTS never truncates the frame in progress; the SM completes the stop bits and then waits in pIdle.
- When undefined: no CTS port; loads depend on TF_EF only.

Test Plan:
- Reset recovery: CE_16x = 1 every Clk, TF_EF = 1, Rst pulse → TxD = 1, TxIdle = 1, RE_THR = 0 for 100 Clk.
- 8N1, THR = 0x55, TF_EF = 0 for one load → exactly one RE_THR pulse. TxD per 16-tick bit = 0,1,0,1,0,1,0,1,0,1. TxIdle returns after 160 ticks.
- 7E2 (Len = 1, NumStop = 1, Par = 1), THR = 0x41 → bits 0, 1,0,0,0,0,0,1, parity 0, stop 1, stop 1 (11 bits). Repeat with Par = 0 (odd) → parity 1.
- Back-to-back: TF_EF held 0 with THR = 0xA5 then 0x3C, 8N1 → RE_THR pulses exactly 160 ticks apart. Second start bit immediately follows the first stop bit. TxIdle stays 0 throughout.
- Mid-frame abort: Rst asserted in pShift3 → TxD = 1 and TxIdle = 1 on the next Clk. A following load transmits a full, correct frame.
- With UART_TXSM_CTS_EN: CTS = 0 with TF_EF = 0 → no RE_THR, TxD = 1. CTS → 1 → load occurs within 3 Clk plus the next CE_16x. CTS → 0 mid-frame → frame completes, then the SM holds in pIdle.

Source files
------------

// File: rtl/uart_txsm.sv
// uart_txsm: UART transmit state machine and shift register (start, 7/8 data bits LSB first,
// optional parity, 1/2 stop bits). Define UART_TXSM_CTS_EN to add CTS flow control on loads.
module uart_txsm #(
  parameter int pBitTime = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       CE_16x,
  input  logic       Len,
  input  logic       NumStop,
  input  logic       ParEn,
  input  logic [1:0] Par,
  input  logic       TF_EF,
  input  logic [7:0] THR,
`ifdef UART_TXSM_CTS_EN
  input  logic       CTS,
`endif
  output logic       RE_THR,
  output logic       TxD,
  output logic       TxIdle,
  output logic       TxStart,
  output logic       TxShift,
  output logic       TxParity,
  output logic       TxStop,
  output logic       TxBusy
);

  localparam int cnt_w = $clog2(pBitTime);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(pBitTime - 1);

  typedef enum logic [3:0] {
    pIdle   = 4'd0,
    pStart  = 4'd1,
    pShift0 = 4'd2,
    pShift1 = 4'd3,
    pShift2 = 4'd4,
    pShift3 = 4'd5,
    pShift4 = 4'd6,
    pShift5 = 4'd7,
    pShift6 = 4'd8,
    pShift7 = 4'd9,
    pParity = 4'd10,
    pStop2  = 4'd11,
    pStop1  = 4'd12
  } state_t;

  state_t           state, state_nxt;
  logic [cnt_w-1:0] bcnt;
  logic [7:0]       tsr;
  logic [7:0]       par_data;
  logic             len_q, stop_q, paren_q, par_bit;
  logic             tc, load, cts_ok, txd_nxt, par_calc;

`ifdef UART_TXSM_CTS_EN
  logic cts_meta, cts_sync;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cts_meta <= 1'b0;
      cts_sync <= 1'b0;
    end else begin
      cts_meta <= CTS;
      cts_sync <= cts_meta;
    end
  end

  assign cts_ok = cts_sync;
`else
  assign cts_ok = 1'b1;
`endif

  assign tc = CE_16x && (bcnt == '0);

  // Parity is fixed at load time so later format changes cannot disturb the frame
  always_comb begin
    par_data = Len ? {1'b0, THR[6:0]} : THR;
    case (Par)
      2'd0:    par_calc = ~^par_data;
      2'd1:    par_calc = ^par_data;
      2'd2:    par_calc = 1'b0;
      default: par_calc = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      pIdle:
        if (CE_16x && !TF_EF && cts_ok) begin
          load      = 1'b1;
          state_nxt = pStart;
        end
      pStart:  if (tc) state_nxt = pShift0;
      pShift0: if (tc) state_nxt = pShift1;
      pShift1: if (tc) state_nxt = pShift2;
      pShift2: if (tc) state_nxt = pShift3;
      pShift3: if (tc) state_nxt = pShift4;
      pShift4: if (tc) state_nxt = pShift5;
      pShift5: if (tc) state_nxt = pShift6;
      pShift6: if (tc) state_nxt = len_q ? pParity : pShift7;
      pShift7: if (tc) state_nxt = paren_q ? pParity : (stop_q ? pStop2 : pStop1);
      pParity: if (tc) state_nxt = stop_q ? pStop2 : pStop1;
      pStop2:  if (tc) state_nxt = pStop1;
      pStop1:
        if (tc) begin
          if (!TF_EF && cts_ok) begin
            load      = 1'b1;
            state_nxt = pStart;
          end else begin
            state_nxt = pIdle;
          end
        end
      default: state_nxt = pIdle;
    endcase
  end

  // TxD is decoded from the next state so the line changes on the same edge as the state
  always_comb begin
    case (state_nxt)
      pStart:  txd_nxt = 1'b0;
      pShift0: txd_nxt = tsr[0];
      pShift1: txd_nxt = tsr[1];
      pShift2: txd_nxt = tsr[2];
      pShift3: txd_nxt = tsr[3];
      pShift4: txd_nxt = tsr[4];
      pShift5: txd_nxt = tsr[5];
      pShift6: txd_nxt = tsr[6];
      pShift7: txd_nxt = tsr[7];
      pParity: txd_nxt = par_bit;
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= pIdle;
      bcnt     <= cnt_last;
      tsr      <= '0;
      len_q    <= 1'b0;
      stop_q   <= 1'b0;
      paren_q  <= 1'b0;
      par_bit  <= 1'b0;
      RE_THR   <= 1'b0;
      TxD      <= 1'b1;
      TxIdle   <= 1'b1;
      TxStart  <= 1'b0;
      TxShift  <= 1'b0;
      TxParity <= 1'b0;
      TxStop   <= 1'b0;
      TxBusy   <= 1'b0;
    end else begin
      state    <= state_nxt;
      RE_THR   <= load;
      TxD      <= txd_nxt;
      TxIdle   <= (state_nxt == pIdle);
      TxStart  <= (state_nxt == pStart);
      TxShift  <= (state_nxt >= pShift0) && (state_nxt <= pShift7);
      TxParity <= (state_nxt == pParity);
      TxStop   <= (state_nxt == pStop1) || (state_nxt == pStop2);
      TxBusy   <= (state_nxt != pIdle);
      if (state == pIdle)
        bcnt <= cnt_last;
      else if (CE_16x)
        bcnt <= bcnt - cnt_w'(1);
      if (load) begin
        tsr     <= THR;
        len_q   <= Len;
        stop_q  <= NumStop;
        paren_q <= ParEn;
        par_bit <= par_calc;
      end
    end
  end

endmodule

// File: tb/tb_uart_txsm.sv
// tb_uart_txsm: scoreboard bench for uart_txsm; expected frames come from a bit-list model
// and are checked by an independent monitor sampling TxD mid-bit.
module tb_uart_txsm;

  logic       Clk = 1'b0;
  logic       Rst, CE_16x, Len, NumStop, ParEn, TF_EF;
  logic [1:0] Par;
  logic [7:0] THR;
  logic       RE_THR, TxD, TxIdle, TxStart, TxShift, TxParity, TxStop, TxBusy;
`ifdef UART_TXSM_CTS_EN
  logic       CTS;
`endif

  typedef struct {
    logic [11:0] bits;
    int          nb;
    int          ndata;
    bit          haspar;
    bit          chain;
  } frame_t;

  frame_t sb[$];
  int     compared = 0;
  int     mismatched = 0;
  bit     ce_mode = 1'b0;
  bit     mon_en = 1'b0;
  bit     mon_busy = 1'b0;
  bit     re_prev = 1'b0;
  logic   tf_q = 1'b1;

  always #5 Clk = ~Clk;

  uart_txsm #(.pBitTime(16)) dut (
    .Clk(Clk), .Rst(Rst), .CE_16x(CE_16x), .Len(Len), .NumStop(NumStop), .ParEn(ParEn),
    .Par(Par), .TF_EF(TF_EF), .THR(THR),
`ifdef UART_TXSM_CTS_EN
    .CTS(CTS),
`endif
    .RE_THR(RE_THR), .TxD(TxD), .TxIdle(TxIdle), .TxStart(TxStart), .TxShift(TxShift),
    .TxParity(TxParity), .TxStop(TxStop), .TxBusy(TxBusy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic endRun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  // Serial line image of one character: start, data LSB first, optional parity, stops
  function automatic frame_t model(input logic [7:0] d, input logic l, input logic ns,
                                   input logic pe, input logic [1:0] p);
    frame_t f;
    int ones = 0;
    f.bits   = '1;
    f.ndata  = l ? 7 : 8;
    f.haspar = l || pe;
    f.chain  = 1'b0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < f.ndata; i++) begin
      f.bits[i+1] = d[i];
      ones += int'(d[i]);
    end
    f.nb = f.ndata + 1;
    if (f.haspar) begin
      case (p)
        2'd0:    f.bits[f.nb] = (ones % 2 == 0);
        2'd1:    f.bits[f.nb] = (ones % 2 == 1);
        2'd2:    f.bits[f.nb] = 1'b0;
        default: f.bits[f.nb] = 1'b1;
      endcase
      f.nb++;
    end
    f.nb += ns ? 2 : 1;
    return f;
  endfunction

  task automatic waitCe(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge Clk);
      if (CE_16x) k++;
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(TxIdle && !mon_busy) && n < 5000) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("wait_idle", 32'(TxIdle), 32'(1));
  endtask

  task automatic waitLoad(input string name);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!RE_THR && n < 5000);
    if (!RE_THR) begin
      checkOutput(name, 32'(RE_THR), 32'(1));
      endRun();
    end
  endtask

  // Offer one character; chain=1 means it is offered while the previous frame still runs
  task automatic applyStimulus(input logic [7:0] d, input logic l, input logic ns,
                               input logic pe, input logic [1:0] p, input bit chain);
    frame_t f;
    if (!chain) begin
      waitIdle();
      repeat ($urandom_range(0, 4)) @(negedge Clk);
    end
    f = model(d, l, ns, pe, p);
    f.chain = chain;
    sb.push_back(f);
    THR = d; Len = l; NumStop = ns; ParEn = pe; Par = p; TF_EF = 1'b0;
    waitLoad("load_timeout");
    TF_EF = 1'b1;
    {Len, NumStop, ParEn} = 3'($urandom);
    Par = 2'($urandom);
    THR = 8'($urandom);
  endtask

  initial forever begin
    @(negedge Clk);
    CE_16x = ce_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(posedge Clk) tf_q <= TF_EF;

  initial forever begin
    @(negedge Clk);
    if (re_prev) checkOutput("re_thr_width", 32'(RE_THR), 32'(0));
    if (RE_THR) checkOutput("re_thr_while_empty", 32'(tf_q), 32'(0));
    re_prev = RE_THR;
  end

  initial begin : monitor
    frame_t     f;
    bit         chained;
    logic [3:0] exp_flags;
    forever begin
      @(negedge Clk);
      if (mon_en && RE_THR) begin
        mon_busy = 1'b1;
        chained  = 1'b0;
        do begin
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_load: got RE_THR=1 expected no load (t=%0t)", $time);
            chained = 1'b0;
          end else begin
            f = sb.pop_front();
            checkOutput("chain", 32'(chained), 32'(f.chain));
            for (int i = 0; i < f.nb; i++) begin
              waitCe(8);
              @(negedge Clk);
              checkOutput($sformatf("txd_bit%0d", i), 32'(TxD), 32'(f.bits[i]));
              exp_flags = (i == 0) ? 4'b1000 :
                          (i <= f.ndata) ? 4'b0100 :
                          (f.haspar && i == f.ndata + 1) ? 4'b0010 : 4'b0001;
              checkOutput($sformatf("flags_bit%0d", i),
                          32'({TxStart, TxShift, TxParity, TxStop, TxBusy}),
                          32'({exp_flags, 1'b1}));
              waitCe(8);
            end
            @(negedge Clk);
            chained = RE_THR;
            if (!chained)
              checkOutput("idle_after_frame", 32'({TxIdle, TxBusy, TxD}), 32'(3'b101));
          end
        end while (chained);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #800000;
    mismatched++;
    compared++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    Rst = 1'b1; CE_16x = 1'b1; TF_EF = 1'b1;
    Len = 1'b0; NumStop = 1'b0; ParEn = 1'b0; Par = 2'd0; THR = 8'h00;
`ifdef UART_TXSM_CTS_EN
    CTS = 1'b1;
`endif
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      checkOutput("reset_idle", 32'({TxD, TxIdle, RE_THR, TxBusy}), 32'(4'b1100));
    end

    mon_en = 1'b1;
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(8'h41, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    applyStimulus(8'h41, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    applyStimulus(8'h96, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);

    // Abort a frame in the middle of data bit 3, then prove a clean frame follows
    waitIdle();
    mon_en = 1'b0;
    THR = 8'h36; Len = 1'b0; NumStop = 1'b0; ParEn = 1'b0; Par = 2'd0; TF_EF = 1'b0;
    waitLoad("abort_load_timeout");
    TF_EF = 1'b1;
    waitCe(16 * 4 + 8);
    @(negedge Clk);
    checkOutput("abort_in_shift3", 32'({TxShift, TxD}), 32'(2'b10));
    Rst = 1'b1;
    @(negedge Clk);
    checkOutput("abort_reset", 32'({TxD, TxIdle, RE_THR, TxBusy}), 32'(4'b1100));
    Rst = 1'b0;
    repeat (20) @(negedge Clk);
    checkOutput("abort_stays_idle", 32'({TxD, TxIdle, RE_THR}), 32'(3'b110));
    mon_en = 1'b1;
    applyStimulus(8'h36, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    ce_mode = 1'b1;
    for (int i = 0; i < 30; i++)
      applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                    (i > 0) && ($urandom_range(0, 2) != 0));

`ifdef UART_TXSM_CTS_EN
    begin : cts_phase
      frame_t f;
      int     n;
      waitIdle();
      ce_mode = 1'b0;
      CTS = 1'b0;
      repeat (4) @(negedge Clk);
      THR = 8'hC3; Len = 1'b0; NumStop = 1'b0; ParEn = 1'b0; Par = 2'd0; TF_EF = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge Clk);
        checkOutput("cts_block", 32'({RE_THR, TxD}), 32'(2'b01));
      end
      f = model(8'hC3, 1'b0, 1'b0, 1'b0, 2'd0);
      sb.push_back(f);
      CTS = 1'b1;
      n = 0;
      do begin
        @(negedge Clk);
        n++;
      end while (!RE_THR && n < 20);
      checkOutput("cts_latency", 32'(RE_THR && n <= 4), 32'(1));
      THR = 8'h5A;
      CTS = 1'b0;
      repeat (400) @(negedge Clk);
      checkOutput("cts_hold_idle", 32'({TxIdle, RE_THR}), 32'(2'b10));
      f = model(8'h5A, 1'b0, 1'b0, 1'b0, 2'd0);
      sb.push_back(f);
      CTS = 1'b1;
      waitLoad("cts_resume_timeout");
      TF_EF = 1'b1;
    end
`endif

    waitIdle();
    repeat (5) @(negedge Clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'(0));
    endRun();
  end

endmodule
